pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_pkg.sv | 24 ++
 rtl/pc_ctrl_if.sv | 28 ++
 rtl/pc_ctrl_branch_cond.sv | 23 ++
 rtl/pc_ctrl.sv | 98 +++++++++
 tb/tb_pc_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the program-counter controller: next-PC operations,
// branch funct3 codes and the fetch FSM state type.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    NPC_PC4  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_op_e;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch/next-PC bus between the decode/ALU side (master) and pc_ctrl (slave).
// Handshake: pc_ctrl asserts if_req for the address on pc; the PC advances only on a
// cycle where if_req, if_ack are both high and stall is low; stall always wins over if_ack.
interface pc_ctrl_if;
  logic        stall;
  logic [1:0]  npc_op;
  logic [2:0]  br_funct;
  logic        zero;
  logic        sgn;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        if_ack;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        if_req;
  logic        redirect;
  logic        misalign;

  modport master (
    output stall, npc_op, br_funct, zero, sgn, imm, rs1, if_ack,
    input  pc, pc4, if_req, redirect, misalign
  );

  modport slave (
    input  stall, npc_op, br_funct, zero, sgn, imm, rs1, if_ack,
    output pc, pc4, if_req, redirect, misalign
  );
endinterface

// File: rtl/pc_ctrl_branch_cond.sv
// Conditional-branch decision from funct3 and the rs1-rs2 ALU flags.
// Unknown funct3 codes resolve to not-taken; sgn is trusted as given.
module branch_cond
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] br_funct,
  input  logic       zero,
  input  logic       sgn,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_funct)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = sgn;
      F3_BGE:  taken = !sgn;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: a BOOT/RUN fetch FSM plus next-PC selection with
// one-cycle redirect and misalign pulses.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      rst,
  pc_ctrl_if.slave  bus,
  output pc_state_e dbg_state
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;

  logic        br_taken;
  logic        taken;
  logic        update;
  logic [31:0] br_target;
  logic [31:0] jalr_sum;
  logic [31:0] target;

  branch_cond u_branch_cond (
    .br_funct (bus.br_funct),
    .zero     (bus.zero),
    .sgn      (bus.sgn),
    .taken    (br_taken)
  );

  // Target and taken qualification; all adds wrap modulo 2^32.
  always_comb begin
    br_target = pc_q + bus.imm;
    jalr_sum  = bus.rs1 + bus.imm;
    target    = br_target;
    taken     = 1'b0;
    case (npc_op_e'(bus.npc_op))
      NPC_PC4: taken = 1'b0;
      NPC_BR:  taken = br_taken;
      NPC_JAL: taken = 1'b1;
      NPC_JALR: begin
        taken  = 1'b1;
        target = jalr_sum & ~32'd1;
      end
      default: taken = 1'b0;
    endcase
  end

  assign update = (state_q == ST_RUN) && bus.if_ack && !bus.stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (update) begin
          // A taken target with bit1 set is refused: PC stays put and we flag it.
          if (taken && target[1]) begin
            misalign_d = 1'b1;
          end else if (taken) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc4      = pc_q + PC_STEP;
  assign bus.if_req   = (state_q == ST_RUN) && !rst;
  assign bus.redirect = redirect_q;
  assign bus.misalign = misalign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed vector table followed by random traffic
// checked against a reference model of the next-PC rules.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic      clk = 1'b0;
  logic      rst;
  pc_state_e dbg_state;

  always #5 clk = ~clk;

  pc_ctrl_if bus ();

  pc_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ack;
    logic [1:0]  op;
    logic [2:0]  funct;
    logic        zero;
    logic        sgn;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        exp_if_req;
    logic [31:0] exp_pc;
    logic        exp_red;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: running flag plus architectural outputs.
  bit          m_run = 1'b0;
  logic [31:0] m_pc  = RESET_PC;
  bit          m_red = 1'b0;
  bit          m_mis = 1'b0;

  function automatic vec_t mk(logic r, logic st, logic ack, logic [1:0] op, logic [2:0] f,
                              logic z, logic s, logic [31:0] imm, logic [31:0] rs1,
                              logic ireq, logic [31:0] epc, logic ered, logic emis);
    vec_t v;
    v.rst = r; v.stall = st; v.ack = ack; v.op = op; v.funct = f; v.zero = z; v.sgn = s;
    v.imm = imm; v.rs1 = rs1; v.exp_if_req = ireq; v.exp_pc = epc; v.exp_red = ered;
    v.exp_mis = emis;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Next-PC rules written directly from the instruction semantics.
  task automatic model_step(input vec_t v);
    bit          tk;
    logic [31:0] tgt;
    if (v.rst) begin
      m_pc = RESET_PC; m_run = 1'b0; m_red = 1'b0; m_mis = 1'b0;
      return;
    end
    m_red = 1'b0; m_mis = 1'b0;
    if (!m_run) begin
      m_run = 1'b1;
      return;
    end
    if (!v.ack || v.stall) return;
    case (v.op)
      2'd0: tk = 1'b0;
      2'd1: tk = (v.funct == 3'd0) ? v.zero : (v.funct == 3'd1) ? !v.zero :
                 (v.funct == 3'd4) ? v.sgn  : (v.funct == 3'd5) ? !v.sgn : 1'b0;
      default: tk = 1'b1;
    endcase
    tgt = (v.op == 2'd3) ? ((v.rs1 + v.imm) / 2) * 2 : m_pc + v.imm;
    if (tk && ((tgt % 4) >= 2)) m_mis = 1'b1;
    else if (tk) begin m_pc = tgt; m_red = 1'b1; end
    else m_pc = m_pc + 32'd4;
  endtask

  task automatic do_cycle(input vec_t v, input bit use_tbl);
    logic        e_req;
    rst          = v.rst;
    bus.stall    = v.stall;
    bus.if_ack   = v.ack;
    bus.npc_op   = v.op;
    bus.br_funct = v.funct;
    bus.zero     = v.zero;
    bus.sgn      = v.sgn;
    bus.imm      = v.imm;
    bus.rs1      = v.rs1;
    #1;
    e_req = use_tbl ? v.exp_if_req : (m_run && !v.rst);
    check("if_req", {31'd0, bus.if_req}, {31'd0, e_req});
    if (!use_tbl) check("state", {31'd0, dbg_state == ST_RUN}, {31'd0, m_run});
    model_step(v);
    @(posedge clk);
    #1;
    if (use_tbl) begin
      check("pc", bus.pc, v.exp_pc);
      check("pc4", bus.pc4, v.exp_pc + 32'd4);
      check("redirect", {31'd0, bus.redirect}, {31'd0, v.exp_red});
      check("misalign", {31'd0, bus.misalign}, {31'd0, v.exp_mis});
    end else begin
      check("rnd_pc", bus.pc, m_pc);
      check("rnd_pc4", bus.pc4, m_pc + 32'd4);
      check("rnd_redirect", {31'd0, bus.redirect}, {31'd0, m_red});
      check("rnd_misalign", {31'd0, bus.misalign}, {31'd0, m_mis});
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] r;
    logic [2:0]  f3[6];
    f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd2, 3'd7};

    //             rst st ack op funct z s imm            rs1           req pc            red mis
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        1, 32'h4,         0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        1, 32'h8,         0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        1, 32'hC,         0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 32'hF4,        32'h0,        1, 32'h100,       1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 32'hFFFF_FFF8, 32'h0,        1, 32'hF8,        1, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 32'h8,         32'h0,        1, 32'h100,       1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,        1, 32'h104,       0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 32'h4,         32'h2001,     1, 32'h2004,      1, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 32'h6,         32'h0,        1, 32'h2004,      0, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 0, 32'h10,        32'h0,        1, 32'h2004,      0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 32'h10,        32'h0,        1, 32'h2004,      0, 0));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 32'h10,        32'h0,        1, 32'h2004,      0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 32'h10,        32'h0,        1, 32'h2014,      1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        1, 32'h2018,      0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 32'hFFFF_DFE4, 32'h0,        1, 32'hFFFF_FFFC, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        1, 32'h0,         0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4, 0, 1, 32'h40,        32'h0,        1, 32'h40,        1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 5, 0, 1, 32'h40,        32'h0,        1, 32'h44,        0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 32'h20,        32'h0,        1, 32'h64,        1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 2, 1, 1, 32'h20,        32'h0,        1, 32'h68,        0, 0));
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 32'h100,       32'h0,        0, RESET_PC,      0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        0, RESET_PC,      0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,        1, RESET_PC + 4,  0, 0));

    foreach (tbl[i]) do_cycle(tbl[i], 1'b1);

    for (int i = 0; i < 400; i++) begin
      r       = $urandom;
      v.rst   = ($urandom_range(0, 39) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.ack   = ($urandom_range(0, 3) != 0);
      v.op    = 2'($urandom_range(0, 3));
      v.funct = f3[$urandom_range(0, 5)];
      v.zero  = 1'($urandom_range(0, 1));
      v.sgn   = 1'($urandom_range(0, 1));
      v.imm   = {{20{r[11]}}, r[11:0]};
      if ($urandom_range(0, 2) != 0) v.imm[1:0] = 2'b00;
      v.rs1   = $urandom;
      if ($urandom_range(0, 1) == 0) v.rs1[1] = 1'b0;
      v.exp_if_req = 1'b0; v.exp_pc = '0; v.exp_red = 1'b0; v.exp_mis = 1'b0;
      do_cycle(v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
